axis_pkt_replay_source: RTL and testbench
=========================================

# axis_pkt_replay_source

Synthesizable AXI4-Stream packet source that replays a preloaded table of beats onto a 256-bit master port. It is the transmit-side counterpart of the simulation stream recorders and drives stimulus into the output-queue/DMA datapath in hardware. Beats are written into an internal LUT-RAM table through a config port, then replayed on `start` with a configurable repeat count and inter-packet gap.

## Interface
- C_M_AXIS_DATA_WIDTH, 256, tdata width
- C_M_AXIS_TUSER_WIDTH, 128, tuser width
- C_ADDR_WIDTH, 6, table address width; depth = 2^C_ADDR_WIDTH
- C_GAP_WIDTH, 8, inter-packet gap counter width

- aclk  in  1  clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- cfg_we  in  1  table write strobe
- cfg_addr  in  C_ADDR_WIDTH  table write address
- cfg_tdata  in  C_M_AXIS_DATA_WIDTH  beat data
- cfg_tstrb  in  C_M_AXIS_DATA_WIDTH/8  beat byte strobes
- cfg_tuser  in  C_M_AXIS_TUSER_WIDTH  beat sideband
- cfg_tlast  in  1  beat ends a packet
- cfg_last_addr  in  C_ADDR_WIDTH  last table entry of a pass
- cfg_repeat  in  16  passes to send; 0 is treated as 1
- cfg_gap  in  C_GAP_WIDTH  idle cycles after each tlast beat
- start  in  1  begin replay (one-cycle pulse)
- busy  out  1  replay in progress
- done  out  1  one-cycle pulse on final beat accepted
- beats_sent  out  32  accepted beats since last start
- pkts_sent  out  32  accepted tlast beats since last start
- m_axis_tdata  out  C_M_AXIS_DATA_WIDTH
- m_axis_tstrb  out  C_M_AXIS_DATA_WIDTH/8
- m_axis_tuser  out  C_M_AXIS_TUSER_WIDTH
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1

## Operation
- States: IDLE, SEND, GAP. Reset → IDLE.
- Reset values: tvalid, tlast, busy, done = 0; tdata/tstrb/tuser = 0; beats_sent, pkts_sent = 0; rd_ptr = 0. Table contents are not cleared by reset.
- Table writes are accepted only in IDLE; cfg_we while busy is ignored.
- IDLE + start:
  - Latch cfg_last_addr, cfg_repeat (0→1) and cfg_gap.
  - Clear both counters, set rd_ptr = 0, load output registers from entry 0.
  - Enter SEND with busy = 1.
- start while busy is ignored. start and cfg_we in the same IDLE cycle: the write lands, and replay reads the pre-write table.
- SEND: tvalid = 1, outputs show entry[rd_ptr]. Outputs are held stable until handshake (tvalid & tready). On handshake:
  - beats_sent += 1; if tlast, pkts_sent += 1. Counters wrap at 2^32.
  - If rd_ptr == latched last_addr and the remaining pass count == 1: pulse done, busy → 0, tvalid → 0, go IDLE. No gap is inserted.
  - Otherwise advance: rd_ptr + 1, or 0 at end of pass with the pass count decremented. Load the next entry's outputs.
  - If the accepted beat had tlast and gap > 0: go to GAP, tvalid → 0. Otherwise stay in SEND, tvalid stays 1.
- GAP: a down-counter from the latched gap. tvalid = 0. Returns to SEND when the count expires.
- A last entry without tlast is legal. The next pass continues the same packet with no gap.
- Reset mid-packet: tvalid drops at the reset edge regardless of tready. This truncates the packet and is intended.

## Timing
- start sampled at edge t → tvalid = 1 during cycle t+1 with entry 0.
- Back-to-back throughput is one beat per cycle while tready = 1. There are no bubbles except programmed gaps.
- tlast handshake at edge e with gap = G > 0: tvalid = 0 for exactly G cycles, high again in cycle e+G+1.
- done is high for the single cycle following the final handshake edge. busy falls at that same edge.
- All outputs are registered. There is no combinational path from tready to any output.

## Test plan
- Load 4 entries (tlast on entries 1 and 3), last_addr = 3, repeat = 1, gap = 0, tready = 1:
  - 4 consecutive beats starting the cycle after start.
  - done in the cycle after beat 3.
  - beats_sent = 4, pkts_sent = 2.
- Same table, gap = 3:
  - tvalid low for exactly 3 cycles after beat 1.
  - No gap after beat 3; done follows immediately.
- Same table, repeat = 3, tready toggling 1/0 each cycle:
  - 12 beats delivered in order 0..3,0..3,0..3.
  - Data held stable while tready = 0.
  - beats_sent = 12, pkts_sent = 6.
- Repeat = 0: behaves as repeat = 1. start during busy and cfg_we during busy are ignored, and the table is unchanged on a second run.
- Reset asserted mid-pass with tready = 0:
  - tvalid = 0, busy = 0 and counters = 0 in the next cycle.
  - A subsequent start replays the intact table from entry 0.
- Last entry without tlast, repeat = 2, gap = 5: no gap at the pass boundary; gaps occur only after tlast beats.

Source files
------------

// File: rtl/axis_pkt_replay_source.sv
// AXI4-Stream packet source: beats preloaded into a LUT-RAM table are replayed on
// start, with a repeat count and an idle gap after every tlast beat.
module axis_pkt_replay_source #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_ADDR_WIDTH         = 6,
    parameter int C_GAP_WIDTH          = 8
) (
    input  logic                              aclk,
    input  logic                              reset,
    input  logic                              cfg_we,
    input  logic [C_ADDR_WIDTH-1:0]           cfg_addr,
    input  logic [C_M_AXIS_DATA_WIDTH-1:0]    cfg_tdata,
    input  logic [C_M_AXIS_DATA_WIDTH/8-1:0]  cfg_tstrb,
    input  logic [C_M_AXIS_TUSER_WIDTH-1:0]   cfg_tuser,
    input  logic                              cfg_tlast,
    input  logic [C_ADDR_WIDTH-1:0]           cfg_last_addr,
    input  logic [15:0]                       cfg_repeat,
    input  logic [C_GAP_WIDTH-1:0]            cfg_gap,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic [31:0]                       beats_sent,
    output logic [31:0]                       pkts_sent,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast
);

    localparam int DEPTH      = 1 << C_ADDR_WIDTH;
    localparam int STRB_WIDTH = C_M_AXIS_DATA_WIDTH / 8;
    localparam logic [C_ADDR_WIDTH-1:0] ADDR_ZERO = '0;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    typedef struct packed {
        logic [C_M_AXIS_DATA_WIDTH-1:0]  tdata;
        logic [STRB_WIDTH-1:0]           tstrb;
        logic [C_M_AXIS_TUSER_WIDTH-1:0] tuser;
        logic                            tlast;
    } beat_t;

    beat_t tbl [DEPTH];

    state_t                   state, state_d;
    beat_t                    out_q, out_d;
    logic                     valid_d, busy_d, done_d;
    logic [C_ADDR_WIDTH-1:0]  rd_ptr, rd_ptr_d, next_ptr;
    logic [C_ADDR_WIDTH-1:0]  last_q, last_d;
    logic [15:0]              pass_left, pass_d;
    logic [C_GAP_WIDTH-1:0]   gap_q, gap_d, gap_cnt, gap_cnt_d;
    logic [31:0]              beats_d, pkts_d;

    // NOTE: the table has no reset; its contents must survive reset, and a reset
    // port on the array would also stop it mapping onto LUT-RAM.
    always_ff @(posedge aclk) begin
        if (cfg_we && state == IDLE)
            tbl[cfg_addr] <= {cfg_tdata, cfg_tstrb, cfg_tuser, cfg_tlast};
    end

    // NOTE: every variable gets its hold value first so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state;
        out_d     = out_q;
        valid_d   = m_axis_tvalid;
        busy_d    = busy;
        done_d    = 1'b0;
        rd_ptr_d  = rd_ptr;
        last_d    = last_q;
        pass_d    = pass_left;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt;
        beats_d   = beats_sent;
        pkts_d    = pkts_sent;
        next_ptr  = (rd_ptr == last_q) ? ADDR_ZERO : rd_ptr + C_ADDR_WIDTH'(1);

        unique case (state)
            IDLE: begin
                if (start) begin
                    last_d   = cfg_last_addr;
                    pass_d   = (cfg_repeat == 16'd0) ? 16'd1 : cfg_repeat;
                    gap_d    = cfg_gap;
                    beats_d  = '0;
                    pkts_d   = '0;
                    rd_ptr_d = ADDR_ZERO;
                    out_d    = tbl[ADDR_ZERO];
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (m_axis_tvalid && m_axis_tready) begin
                    beats_d = beats_sent + 32'd1;
                    if (out_q.tlast)
                        pkts_d = pkts_sent + 32'd1;
                    if (rd_ptr == last_q && pass_left == 16'd1) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        rd_ptr_d = next_ptr;
                        if (rd_ptr == last_q)
                            pass_d = pass_left - 16'd1;
                        out_d = tbl[next_ptr];
                        // The gap follows packet ends only, never a bare pass boundary.
                        if (out_q.tlast && gap_q != '0) begin
                            gap_cnt_d = gap_q;
                            valid_d   = 1'b0;
                            state_d   = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_cnt == C_GAP_WIDTH'(1)) begin
                    valid_d = 1'b1;
                    state_d = SEND;
                end else begin
                    gap_cnt_d = gap_cnt - C_GAP_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge aclk) begin
        if (reset) begin
            state         <= IDLE;
            out_q         <= '0;
            m_axis_tvalid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            rd_ptr        <= '0;
            last_q        <= '0;
            pass_left     <= '0;
            gap_q         <= '0;
            gap_cnt       <= '0;
            beats_sent    <= '0;
            pkts_sent     <= '0;
        end else begin
            state         <= state_d;
            out_q         <= out_d;
            m_axis_tvalid <= valid_d;
            busy          <= busy_d;
            done          <= done_d;
            rd_ptr        <= rd_ptr_d;
            last_q        <= last_d;
            pass_left     <= pass_d;
            gap_q         <= gap_d;
            gap_cnt       <= gap_cnt_d;
            beats_sent    <= beats_d;
            pkts_sent     <= pkts_d;
        end
    end

    assign m_axis_tdata = out_q.tdata;
    assign m_axis_tstrb = out_q.tstrb;
    assign m_axis_tuser = out_q.tuser;
    assign m_axis_tlast = out_q.tlast;

endmodule

// File: tb/tb_axis_pkt_replay_source.sv
// Testbench for axis_pkt_replay_source.
module tb_axis_pkt_replay_source;

    localparam int DW = 256;
    localparam int UW = 128;
    localparam int SW = DW / 8;
    localparam int AW = 6;
    localparam int GW = 8;
    localparam int NC = 64;

    logic          aclk = 1'b0;
    logic          reset;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_tdata;
    logic [SW-1:0] cfg_tstrb;
    logic [UW-1:0] cfg_tuser;
    logic          cfg_tlast;
    logic [AW-1:0] cfg_last_addr;
    logic [15:0]   cfg_repeat;
    logic [GW-1:0] cfg_gap;
    logic          start;
    logic          busy;
    logic          done;
    logic [31:0]   beats_sent;
    logic [31:0]   pkts_sent;
    logic [DW-1:0] m_axis_tdata;
    logic [SW-1:0] m_axis_tstrb;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;

    always #5 aclk = ~aclk;

    axis_pkt_replay_source #(
        .C_M_AXIS_DATA_WIDTH (DW),
        .C_M_AXIS_TUSER_WIDTH(UW),
        .C_ADDR_WIDTH        (AW),
        .C_GAP_WIDTH         (GW)
    ) dut (
        .aclk         (aclk),
        .reset        (reset),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_tdata    (cfg_tdata),
        .cfg_tstrb    (cfg_tstrb),
        .cfg_tuser    (cfg_tuser),
        .cfg_tlast    (cfg_tlast),
        .cfg_last_addr(cfg_last_addr),
        .cfg_repeat   (cfg_repeat),
        .cfg_gap      (cfg_gap),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .beats_sent   (beats_sent),
        .pkts_sent    (pkts_sent),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tstrb (m_axis_tstrb),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast)
    );

    typedef struct {
        logic [DW-1:0] tdata;
        logic [SW-1:0] tstrb;
        logic [UW-1:0] tuser;
        logic          tlast;
    } beat_t;

    typedef struct {
        string name;
        int    last_addr;
        int    rep;
        int    gap;
        int    mode;         // 0: tready always 1, 1: tready high on odd cycles
        bit    e3_last;      // tlast of table entry 3 for this run
        int    inj_start_c;  // cycle of a start pulse while busy, -1 for none
        int    inj_we_c;     // cycle of a table write while busy, -1 for none
        bit    we_with_start;
    } scen_t;

    beat_t model_tbl [4];
    beat_t sb_q [$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t make_beat(input int idx, input int salt, input bit last);
        beat_t     b;
        logic [7:0] i8;
        logic [7:0] s8;
        i8 = idx[7:0];
        s8 = salt[7:0];
        b.tdata = {8{s8, 8'h5a, i8, 8'hc3}};
        b.tstrb = ~(SW'(1) << idx);
        b.tuser = {4{i8, s8, 16'hbeef}};
        b.tlast = last;
        return b;
    endfunction

    function automatic scen_t mk_scen(input string name, input int last_addr, input int rep,
                                      input int gap, input int mode, input bit e3_last,
                                      input int inj_start_c, input int inj_we_c,
                                      input bit we_with_start);
        scen_t s;
        s.name = name;
        s.last_addr = last_addr;
        s.rep = rep;
        s.gap = gap;
        s.mode = mode;
        s.e3_last = e3_last;
        s.inj_start_c = inj_start_c;
        s.inj_we_c = inj_we_c;
        s.we_with_start = we_with_start;
        return s;
    endfunction

    function automatic bit ready_at(input int mode, input int c);
        return (mode == 0) ? 1'b1 : (c % 2 == 1);
    endfunction

    task automatic drive_cfg(input int idx, input beat_t b);
        cfg_addr  = AW'(idx);
        cfg_tdata = b.tdata;
        cfg_tstrb = b.tstrb;
        cfg_tuser = b.tuser;
        cfg_tlast = b.tlast;
    endtask

    task automatic write_entry(input int idx, input beat_t b);
        @(negedge aclk);
        drive_cfg(idx, b);
        cfg_we = 1'b1;
        @(negedge aclk);
        cfg_we = 1'b0;
        model_tbl[idx] = b;
    endtask

    task automatic run_scenario(input scen_t s);
        beat_t         pre_tbl [4];
        beat_t         exp_b;
        beat_t         new0;
        int            order [$];
        int            rep_eff;
        int            npkts;
        int            c;
        int            bi;
        bit            hold_pend;
        logic [DW-1:0] hold_data;
        logic [NC-1:0] exp_valid, exp_done, exp_busy;
        logic [NC-1:0] act_valid, act_done, act_busy;

        if (model_tbl[3].tlast != s.e3_last) begin
            exp_b = model_tbl[3];
            exp_b.tlast = s.e3_last;
            write_entry(3, exp_b);
        end

        // Expected beat order, scoreboard contents and per-cycle traces.
        rep_eff = (s.rep == 0) ? 1 : s.rep;
        pre_tbl = model_tbl;
        npkts = 0;
        for (int p = 0; p < rep_eff; p++)
            for (int i = 0; i <= s.last_addr; i++) begin
                order.push_back(i);
                sb_q.push_back(pre_tbl[i]);
                if (pre_tbl[i].tlast) npkts++;
            end
        exp_valid = '0;
        exp_done  = '0;
        exp_busy  = '0;
        c = 0;
        for (int b = 0; b < order.size(); b++) begin
            while (!ready_at(s.mode, c) && c < NC) begin
                exp_valid[c] = 1'b1;
                c++;
            end
            if (c < NC) exp_valid[c] = 1'b1;
            c++;
            if (pre_tbl[order[b]].tlast && s.gap > 0 && b != order.size() - 1)
                c += s.gap;
        end
        if (c < NC) exp_done[c] = 1'b1;
        for (int i = 0; i < c && i < NC; i++) exp_busy[i] = 1'b1;

        @(negedge aclk);
        cfg_last_addr = AW'(s.last_addr);
        cfg_repeat    = 16'(s.rep);
        cfg_gap       = GW'(s.gap);
        start = 1'b1;
        new0 = make_beat(0, 8'h77, 1'b0);
        if (s.we_with_start) begin
            drive_cfg(0, new0);
            cfg_we = 1'b1;
        end
        @(negedge aclk);
        start  = 1'b0;
        cfg_we = 1'b0;
        if (s.we_with_start) model_tbl[0] = new0;

        hold_pend = 1'b0;
        hold_data = '0;
        bi = 0;
        for (int cc = 0; cc < NC; cc++) begin
            act_valid[cc] = m_axis_tvalid;
            act_done[cc]  = done;
            act_busy[cc]  = busy;
            if (hold_pend) begin
                check($sformatf("%s/hold_c%0d", s.name, cc), m_axis_tdata, hold_data);
                hold_pend = 1'b0;
            end
            m_axis_tready = ready_at(s.mode, cc);
            if (m_axis_tvalid && m_axis_tready) begin
                if (sb_q.size() == 0) begin
                    check($sformatf("%s/extra_beat_c%0d", s.name, cc), DW'(1), DW'(0));
                end else begin
                    exp_b = sb_q.pop_front();
                    check($sformatf("%s/beat%0d_data", s.name, bi), m_axis_tdata, exp_b.tdata);
                    check($sformatf("%s/beat%0d_side", s.name, bi),
                          DW'({m_axis_tlast, m_axis_tstrb, m_axis_tuser}),
                          DW'({exp_b.tlast, exp_b.tstrb, exp_b.tuser}));
                end
                bi++;
            end else if (m_axis_tvalid) begin
                hold_pend = 1'b1;
                hold_data = m_axis_tdata;
            end
            start  = (cc == s.inj_start_c);
            cfg_we = (cc == s.inj_we_c);
            if (cfg_we) drive_cfg(3, make_beat(3, 8'hee, 1'b0));
            @(negedge aclk);
        end
        start = 1'b0;
        cfg_we = 1'b0;
        m_axis_tready = 1'b0;

        check({s.name, "/valid_trace"}, DW'(act_valid), DW'(exp_valid));
        check({s.name, "/done_trace"},  DW'(act_done),  DW'(exp_done));
        check({s.name, "/busy_trace"},  DW'(act_busy),  DW'(exp_busy));
        check({s.name, "/beats_sent"},  DW'(beats_sent), DW'(order.size()));
        check({s.name, "/pkts_sent"},   DW'(pkts_sent),  DW'(npkts));
        check({s.name, "/beats_missing"}, DW'(sb_q.size()), DW'(0));
        sb_q.delete();
    endtask

    task automatic reset_midpass();
        @(negedge aclk);
        cfg_last_addr = AW'(3);
        cfg_repeat    = 16'd2;
        cfg_gap       = '0;
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        m_axis_tready = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        m_axis_tready = 1'b0;
        check("midreset/beats_before", DW'(beats_sent), DW'(2));
        check("midreset/pkts_before",  DW'(pkts_sent),  DW'(1));
        check("midreset/valid_before", DW'(m_axis_tvalid), DW'(1));
        reset = 1'b1;
        @(negedge aclk);
        check("midreset/tvalid", DW'(m_axis_tvalid), DW'(0));
        check("midreset/busy",   DW'(busy),          DW'(0));
        check("midreset/beats",  DW'(beats_sent),    DW'(0));
        check("midreset/pkts",   DW'(pkts_sent),     DW'(0));
        check("midreset/tdata",  m_axis_tdata,       DW'(0));
        reset = 1'b0;
    endtask

    initial begin
        scen_t scen [8];

        reset = 1'b1;
        cfg_we = 1'b0;
        cfg_addr = '0;
        cfg_tdata = '0;
        cfg_tstrb = '0;
        cfg_tuser = '0;
        cfg_tlast = 1'b0;
        cfg_last_addr = '0;
        cfg_repeat = '0;
        cfg_gap = '0;
        start = 1'b0;
        m_axis_tready = 1'b0;
        repeat (3) @(negedge aclk);
        check("reset/tvalid", DW'(m_axis_tvalid), DW'(0));
        check("reset/tlast",  DW'(m_axis_tlast),  DW'(0));
        check("reset/busy",   DW'(busy),          DW'(0));
        check("reset/done",   DW'(done),          DW'(0));
        check("reset/beats",  DW'(beats_sent),    DW'(0));
        check("reset/pkts",   DW'(pkts_sent),     DW'(0));
        check("reset/tdata",  m_axis_tdata,       DW'(0));
        check("reset/side",   DW'({m_axis_tstrb, m_axis_tuser}), DW'(0));
        reset = 1'b0;

        for (int i = 0; i < 4; i++)
            write_entry(i, make_beat(i, 8'h10, (i == 1 || i == 3)));

        scen[0] = mk_scen("basic",         3, 1, 0, 0, 1'b1, -1, -1, 1'b0);
        scen[1] = mk_scen("gap3",          3, 1, 3, 0, 1'b1, -1, -1, 1'b0);
        scen[2] = mk_scen("toggle_rep3",   3, 3, 0, 1, 1'b1, -1, -1, 1'b0);
        scen[3] = mk_scen("rep0_busy_inj", 3, 0, 0, 0, 1'b1,  2,  0, 1'b0);
        scen[4] = mk_scen("rerun",         3, 1, 0, 0, 1'b1, -1, -1, 1'b0);
        scen[5] = mk_scen("start_with_we", 3, 1, 0, 0, 1'b1, -1, -1, 1'b1);
        scen[6] = mk_scen("no_tlast_end",  3, 2, 5, 0, 1'b0, -1, -1, 1'b0);
        scen[7] = mk_scen("after_reset",   3, 1, 2, 1, 1'b0, -1, -1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            if (i == 7) reset_midpass();
            run_scenario(scen[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

endmodule
